// File: rtl/hist_pkg.sv
// Shared constants for the histogram bin sequencer: state encoding,
// per-group bin-count width and default sample width.
package hist_pkg;

    localparam int unsigned HIST_N_W    = 3;
    localparam int unsigned HIST_DATA_W = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } hist_state_e;

endpackage

// File: rtl/hist_bin_count.sv
// Combinational bin-count unit: how many of four samples fall inside the
// inclusive range [lo, hi]. An inverted range (lo > hi) matches nothing.
module hist_bin_count
    import hist_pkg::*;
#(
    parameter int unsigned DATA_W = HIST_DATA_W
) (
    input  logic [DATA_W-1:0]   i_s1,
    input  logic [DATA_W-1:0]   i_s2,
    input  logic [DATA_W-1:0]   i_s3,
    input  logic [DATA_W-1:0]   i_s4,
    input  logic [DATA_W-1:0]   i_lo,
    input  logic [DATA_W-1:0]   i_hi,
    output logic [HIST_N_W-1:0] o_n
);

    logic [DATA_W-1:0] w_s [4];

    assign w_s[0] = i_s1;
    assign w_s[1] = i_s2;
    assign w_s[2] = i_s3;
    assign w_s[3] = i_s4;

    // Count samples inside the bin range
    always_comb begin
        o_n = '0;
        for (int i = 0; i < 4; i++) begin
            if ((w_s[i] >= i_lo) && (w_s[i] <= i_hi)) begin
                o_n = o_n + HIST_N_W'(1);
            end
        end
    end

endmodule

// File: rtl/hist_bin_sequencer.sv
// Histogram bin sequencer: accepts groups of four samples and scans them
// against one programmable bin per cycle through a single shared
// hist_bin_count unit, accumulating per-bin counts.
// Build option: define HIST_SAT_EN to saturate the accumulators at
// 2^CNT_W-1; by default they wrap modulo 2^CNT_W.
module hist_bin_sequencer
    import hist_pkg::*;
#(
    parameter int unsigned NUM_BINS = 4,
    parameter int unsigned DATA_W   = HIST_DATA_W,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_we,
    input  logic [$clog2(NUM_BINS)-1:0] cfg_idx,
    input  logic [DATA_W-1:0]           cfg_lo,
    input  logic [DATA_W-1:0]           cfg_hi,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_o1,
    input  logic [DATA_W-1:0]           in_o2,
    input  logic [DATA_W-1:0]           in_o3,
    input  logic [DATA_W-1:0]           in_o4,
    input  logic                        clr,
    input  logic [$clog2(NUM_BINS)-1:0] rd_idx,
    output logic [CNT_W-1:0]            rd_count,
    output logic                        busy,
    output logic                        group_done
);

    localparam int unsigned     IDX_W    = $clog2(NUM_BINS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BINS - 1);

    hist_state_e        r_state;
    hist_state_e        w_state_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic               w_accept;
    logic [DATA_W-1:0]  r_s  [4];
    logic [DATA_W-1:0]  r_lo [NUM_BINS];
    logic [DATA_W-1:0]  r_hi [NUM_BINS];
    logic [CNT_W-1:0]   r_acc [NUM_BINS];
    logic [HIST_N_W-1:0] w_n;
    logic [CNT_W-1:0]   w_acc_nxt;

    assign w_accept   = (r_state == ST_IDLE) && in_valid && !clr;
    assign in_ready   = (r_state == ST_IDLE) && !rst && !clr;
    assign busy       = (r_state == ST_SCAN);
    assign group_done = r_done;
    // Index width covers exactly NUM_BINS (a power of two), so every rd_idx is a valid bin
    assign rd_count   = r_acc[rd_idx];

    // Next-state logic: clear aborts, IDLE accepts, SCAN walks the bins
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_done_nxt  = 1'b0;
        if (clr) begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        w_state_nxt = ST_SCAN;
                        w_idx_nxt   = '0;
                    end
                end
                ST_SCAN: begin
                    w_idx_nxt = r_idx + IDX_W'(1);
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = ST_IDLE;
                        w_idx_nxt   = '0;
                        w_done_nxt  = 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // State, bin index and completion pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Sample latch, loaded when a group is accepted
    always_ff @(posedge clk) begin
        if (!rst && w_accept) begin
            r_s[0] <= in_o1;
            r_s[1] <= in_o2;
            r_s[2] <= in_o3;
            r_s[3] <= in_o4;
        end
    end

    // Bin bounds, writable only while idle so a scan sees stable bounds
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(NUM_BINS); k++) begin
                r_lo[k] <= '0;
                r_hi[k] <= '0;
            end
        end else if (cfg_we && (r_state == ST_IDLE) && !clr) begin
            r_lo[cfg_idx] <= cfg_lo;
            r_hi[cfg_idx] <= cfg_hi;
        end
    end

    hist_bin_count #(
        .DATA_W (DATA_W)
    ) u_count (
        .i_s1 (r_s[0]),
        .i_s2 (r_s[1]),
        .i_s3 (r_s[2]),
        .i_s4 (r_s[3]),
        .i_lo (r_lo[r_idx]),
        .i_hi (r_hi[r_idx]),
        .o_n  (w_n)
    );

`ifdef HIST_SAT_EN
    logic [CNT_W:0] w_sum;

    // Saturating add of the current bin count
    always_comb begin
        w_sum     = {1'b0, r_acc[r_idx]} + (CNT_W+1)'(w_n);
        w_acc_nxt = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
    end
`else
    // Wrapping add of the current bin count
    always_comb begin
        w_acc_nxt = r_acc[r_idx] + CNT_W'(w_n);
    end
`endif

    // Accumulators: cleared by reset or clr, updated one bin per scan cycle
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int k = 0; k < int'(NUM_BINS); k++) begin
                r_acc[k] <= '0;
            end
        end else if (r_state == ST_SCAN) begin
            r_acc[r_idx] <= w_acc_nxt;
        end
    end

endmodule

// File: tb/tb_hist_bin_sequencer.sv
// Directed bench for hist_bin_sequencer with a group-level reference model
// checked every cycle, plus literal expectations for the directed cases.
module tb_hist_bin_sequencer;

    localparam int NB    = 4;
    localparam int CW    = 4;
    localparam int MAXV  = (1 << CW) - 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cfg_we = 1'b0;
    logic [1:0]     cfg_idx = '0;
    logic [7:0]     cfg_lo = '0;
    logic [7:0]     cfg_hi = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [7:0]     in_o1 = '0, in_o2 = '0, in_o3 = '0, in_o4 = '0;
    logic           clr = 1'b0;
    logic [1:0]     rd_idx = '0;
    logic [CW-1:0]  rd_count;
    logic           busy;
    logic           group_done;

    int errors = 0;
    int checks = 0;

    // Reference model state: bounds, accumulators, scan cycles left, done pulse
    int m_lo  [NB];
    int m_hi  [NB];
    int m_acc [NB];
    int m_left = 0;
    bit m_done = 1'b0;

    hist_bin_sequencer #(
        .NUM_BINS (NB),
        .DATA_W   (8),
        .CNT_W    (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_lo     (cfg_lo),
        .cfg_hi     (cfg_hi),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_o1      (in_o1),
        .in_o2      (in_o2),
        .in_o3      (in_o3),
        .in_o4      (in_o4),
        .clr        (clr),
        .rd_idx     (rd_idx),
        .rd_count   (rd_count),
        .busy       (busy),
        .group_done (group_done)
    );

    always #10 clk = ~clk;

    function automatic int in_range(int lo, int hi, int s);
        return ((s >= lo) && (s <= hi)) ? 1 : 0;
    endfunction

    function automatic int acc_add(int a, int n);
        int v;
        v = a + n;
`ifdef HIST_SAT_EN
        return (v > MAXV) ? MAXV : v;
`else
        return v % (MAXV + 1);
`endif
    endfunction

    // Group-level model: a whole group is added to every bin at acceptance
    always @(posedge clk) begin
        if (rst) begin
            m_left <= 0;
            m_done <= 1'b0;
            for (int k = 0; k < NB; k++) begin
                m_acc[k] <= 0;
                m_lo[k]  <= 0;
                m_hi[k]  <= 0;
            end
        end else if (clr) begin
            m_left <= 0;
            m_done <= 1'b0;
            for (int k = 0; k < NB; k++) m_acc[k] <= 0;
        end else if (m_left == 0) begin
            m_done <= 1'b0;
            if (cfg_we) begin
                m_lo[cfg_idx] <= int'(cfg_lo);
                m_hi[cfg_idx] <= int'(cfg_hi);
            end
            if (in_valid) begin
                m_left <= NB;
                for (int k = 0; k < NB; k++) begin
                    m_acc[k] <= acc_add(m_acc[k],
                        in_range(m_lo[k], m_hi[k], int'(in_o1)) +
                        in_range(m_lo[k], m_hi[k], int'(in_o2)) +
                        in_range(m_lo[k], m_hi[k], int'(in_o3)) +
                        in_range(m_lo[k], m_hi[k], int'(in_o4)));
                end
            end
        end else begin
            m_left <= m_left - 1;
            m_done <= (m_left == 1);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle, then compare the DUT against the model away from the edge
    task automatic cyc();
        logic [1:0] save;
        @(posedge clk);
        @(negedge clk);
        check("in_ready", int'(in_ready), (m_left == 0 && !rst && !clr) ? 1 : 0);
        check("busy", int'(busy), (m_left != 0) ? 1 : 0);
        check("group_done", int'(group_done), int'(m_done));
        if (m_left == 0) begin
            save = rd_idx;
            for (int k = 0; k < NB; k++) begin
                rd_idx = 2'(k);
                #1;
                check($sformatf("rd_count[%0d]", k), int'(rd_count), m_acc[k]);
            end
            rd_idx = save;
        end
    endtask

    task automatic lit(input int k, input int exp, input string name);
        rd_idx = 2'(k);
        #1;
        check(name, int'(rd_count), exp);
    endtask

    task automatic cfg(input int k, input int lo, input int hi);
        cfg_we  = 1'b1;
        cfg_idx = 2'(k);
        cfg_lo  = 8'(lo);
        cfg_hi  = 8'(hi);
        cyc();
        cfg_we  = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        cyc();
    endtask

    // Send one group; optionally attempt a bin0=[0,0] write during the scan
    task automatic send(input int a, input int b, input int c, input int d, input bit mid_cfg);
        in_o1 = 8'(a); in_o2 = 8'(b); in_o3 = 8'(c); in_o4 = 8'(d);
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        for (int i = 1; i <= NB; i++) begin
            check("scan_ready_low", int'(in_ready), 0);
            check("scan_no_done", int'(group_done), 0);
            if (mid_cfg && i == 1) begin
                cfg_we = 1'b1; cfg_idx = 2'd0; cfg_lo = 8'd0; cfg_hi = 8'd0;
            end
            cyc();
            cfg_we = 1'b0;
        end
        check("done_latency", int'(group_done), 1);
        check("ready_after_scan", int'(in_ready), 1);
    endtask

    initial begin
        // Reset state
        cyc();
        check("rst_ready", int'(in_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(group_done), 0);
        lit(0, 0, "rst_acc0");
        rst = 1'b0;
        cyc();
        check("idle_ready", int'(in_ready), 1);

        // Basic programming and two groups
        cfg(0, 1, 3);
        cfg(1, 1, 9);
        cfg(2, 10, 255);
        cfg(3, 0, 0);
        send(0, 0, 0, 0, 1'b0);
        lit(0, 0, "t1a_acc0"); lit(1, 0, "t1a_acc1");
        lit(2, 0, "t1a_acc2"); lit(3, 4, "t1a_acc3");
        send(1, 1, 1, 1, 1'b0);
        lit(0, 4, "t1b_acc0"); lit(1, 4, "t1b_acc1");
        lit(2, 0, "t1b_acc2"); lit(3, 4, "t1b_acc3");

        // Empty bin and single-value bin
        do_clr();
        cfg(0, 9, 3);
        cfg(1, 7, 7);
        send(7, 7, 3, 200, 1'b0);
        lit(0, 0, "t2_acc0"); lit(1, 2, "t2_acc1"); lit(2, 1, "t2_acc2");

        // Full-range bin driven past the accumulator limit
        do_clr();
        cfg(0, 0, 255);
        for (int g = 0; g < 5; g++) send(1, 2, 3, 4, 1'b0);
`ifdef HIST_SAT_EN
        lit(0, 15, "t3_acc0_sat");
`else
        lit(0, 4, "t3_acc0_wrap");
`endif

        // Clear in the second scan cycle aborts the group
        do_clr();
        cfg(0, 1, 3);
        in_o1 = 8'd2; in_o2 = 8'd2; in_o3 = 8'd2; in_o4 = 8'd2;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        cyc();
        clr = 1'b1;
        cyc();
        check("clr_busy", int'(busy), 0);
        check("clr_ready", int'(in_ready), 0);
        lit(0, 0, "clr_acc0");
        clr = 1'b0;
        cyc();
        check("post_clr_ready", int'(in_ready), 1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("clr_no_done", int'(group_done), 0);
        end
        send(2, 2, 2, 2, 1'b0);
        lit(0, 4, "t4_bounds_kept");

        // Bound write during a scan is ignored
        do_clr();
        send(0, 0, 0, 0, 1'b1);
        lit(0, 0, "t5a_acc0");
        send(0, 0, 0, 0, 1'b0);
        lit(0, 0, "t5b_acc0");
        lit(3, 8, "t5b_acc3");

        // Reset mid-scan with in_valid held
        in_o1 = 8'd0; in_o2 = 8'd0; in_o3 = 8'd0; in_o4 = 8'd0;
        in_valid = 1'b1;
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        check("midrst_ready", int'(in_ready), 0);
        check("midrst_busy", int'(busy), 0);
        lit(3, 0, "midrst_acc3");
        cyc();
        check("midrst_done", int'(group_done), 0);
        rst = 1'b0;
        cyc();
        check("accept_after_rst", int'(busy), 1);
        in_valid = 1'b0;
        for (int i = 0; i < NB; i++) cyc();
        check("t6_done", int'(group_done), 1);
        for (int k = 0; k < NB; k++) lit(k, 4, $sformatf("t6_acc%0d", k));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
